// File: rtl/ram_ctrl.sv
// ram_ctrl: control stage driving a single-port block RAM from button ticks and switches
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset
//   i_sw_data    data written on i_wr_tick
//   i_wr_tick    write i_sw_data at the current address
//   i_up_tick    address +1 (wraps)
//   i_down_tick  address -1 (wraps)
//   i_clr_tick   write zero to every address
//   i_ram_dout   RAM read data, one cycle after address sampled
//   o_ram_we     RAM write enable
//   o_ram_addr   RAM address
//   o_ram_din    RAM write data
//   o_disp_data  last word read back at o_ram_addr
//   o_busy       high outside IDLE
module ram_ctrl #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int AUTO_INC = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [DATA_W-1:0] i_sw_data,
   input  logic              i_wr_tick,
   input  logic              i_up_tick,
   input  logic              i_down_tick,
   input  logic              i_clr_tick,
   input  logic [DATA_W-1:0] i_ram_dout,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_din,
   output logic [DATA_W-1:0] o_disp_data,
   output logic              o_busy
);
   typedef enum logic [2:0] {IDLE, WR, CLR, RD1, RD2} state_t;
   state_t            r_state;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;
   logic [DATA_W-1:0] r_disp;
   logic              r_busy;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_din   <= '0;
         r_disp  <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            // priority chain: only the highest tick acts, the rest are dropped
            IDLE: if (i_clr_tick) begin
                     r_addr  <= '0;
                     r_din   <= '0;
                     r_we    <= 1'b1;
                     r_busy  <= 1'b1;
                     r_state <= CLR;
                  end else if (i_wr_tick) begin
                     r_din   <= i_sw_data;
                     r_we    <= 1'b1;
                     r_busy  <= 1'b1;
                     r_state <= WR;
                  end else if (i_up_tick) begin
                     r_addr  <= r_addr + ADDR_W'(1);
                     r_busy  <= 1'b1;
                     r_state <= RD1;
                  end else if (i_down_tick) begin
                     r_addr  <= r_addr - ADDR_W'(1);
                     r_busy  <= 1'b1;
                     r_state <= RD1;
                  end
            WR: begin
               r_we    <= 1'b0;
               if (AUTO_INC != 0) r_addr <= r_addr + ADDR_W'(1);
               r_state <= RD1;
            end
            // the cycle at the top address is the final write of the sweep
            CLR: if (r_addr == {ADDR_W{1'b1}}) begin
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                    r_state <= RD1;
                 end else r_addr <= r_addr + ADDR_W'(1);
            RD1: r_state <= RD2;
            RD2: begin
               r_disp  <= i_ram_dout;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign o_ram_we    = r_we;
   assign o_ram_addr  = r_addr;
   assign o_ram_din   = r_din;
   assign o_disp_data = r_disp;
   assign o_busy      = r_busy;
endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Control stage directly upstream of the lab's 256x16 single-port block RAM (synchronous write, 1-cycle registered read).
- Turns one-shot button ticks and the 16 slide switches into RAM write, address-step and clear operations.
- Captures RAM read data into a display register that feeds the seven-segment display path.
- All RAM port signals (we, addr, din) are driven only by this block.

Parameters:
ADDR_W, 8, RAM address width (depth = 2^ADDR_W)
DATA_W, 16, RAM data width
AUTO_INC, 1, 1 = address advances by one after each write; 0 = address holds after write

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
sw_data  input  DATA_W  slide-switch data to be written
wr_tick  input  1  one-cycle pulse: write sw_data at current address
up_tick  input  1  one-cycle pulse: address +1
down_tick  input  1  one-cycle pulse: address -1
clr_tick  input  1  one-cycle pulse: write 0 to every address
ram_dout  input  DATA_W  RAM read data, valid one cycle after the address is sampled
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_din  output  DATA_W  RAM write data
disp_data  output  DATA_W  last captured RAM word at ram_addr
busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset is checked on every rising edge and overrides everything.
- Reset values: ram_we=0, ram_addr=0, ram_din=0, disp_data=0, busy=0, state=IDLE.
- A reset in mid-operation (including mid-CLR) aborts the operation immediately. RAM contents already written are kept.
- The FSM states are IDLE, WR, CLR, RD1 and RD2.
- IDLE, tick handling:
  - Ticks are sampled only in IDLE; ticks arriving in any other state are dropped, not queued.
  - Priority when ticks coincide: clr_tick > wr_tick > up_tick > down_tick.
  - When several ticks coincide, only the highest-priority tick acts.
- IDLE, wr_tick:
  - sw_data is latched into ram_din and ram_we is set to 1; next state WR.
  - In WR, ram_we=1 for exactly one cycle, and the RAM writes ram_din at ram_addr on the edge that ends WR.
  - At the end of WR: ram_we is set to 0. If AUTO_INC=1, ram_addr increments, wrapping 255 to 0. Next state RD1.
- IDLE, up_tick / down_tick:
  - ram_addr increments or decrements modulo 2^ADDR_W (255+1=0, 0-1=255); next state RD1.
- IDLE, clr_tick:
  - ram_addr is set to 0, ram_din to 0 and ram_we to 1; next state CLR.
  - In CLR, ram_we stays 1 and ram_addr increments each cycle.
  - The cycle that writes address 255 is the last one. At its end: ram_we is set to 0, ram_addr to 0, and the next state is RD1.
  - Exactly 2^ADDR_W write cycles occur.
- RD1: address stable; the RAM samples it at the end of the cycle; next state RD2.
- RD2: disp_data is loaded from ram_dout at the end of the cycle; next state IDLE.
- Latency, tick edge to updated disp_data:
  - up/down: 3 edges.
  - write: 4 edges.
  - clear: 2^ADDR_W+3 edges.
- With AUTO_INC=1, disp_data after a write shows the contents of the next address, not the word just written.
- With AUTO_INC=0, disp_data after a write shows read-back of the word just written.
- ram_we is never 1 in IDLE, RD1 or RD2.

Test Plan:
- Reset while in CLR at address 0x40: ram_we=0, ram_addr=0, busy=0 on the next edge, state IDLE, no further writes occur.
- Write then step back, AUTO_INC=1: addr 0x00, sw_data=0xBEEF, wr_tick → exactly one ram_we cycle at addr 0x00, ram_addr becomes 0x01. Then down_tick → 3 edges later disp_data=0xBEEF, busy low.
- Address wrap: from addr 0xFF, up_tick → ram_addr=0x00. Then down_tick → ram_addr=0xFF. ram_we stays 0 throughout.
- Simultaneous ticks: wr_tick+up_tick+clr_tick in the same cycle → clear sequence only, 256 consecutive ram_we cycles covering addr 0x00–0xFF with ram_din=0. Then ram_addr=0, disp_data=0x0000.
- Busy drop: up_tick asserted during WR and during RD2 → ignored; final ram_addr reflects the write only.
- AUTO_INC=0: sw_data=0x1234 at addr 0x10, wr_tick → ram_addr stays 0x10, and disp_data=0x1234 four edges after the tick.
